// File: rtl/ff_bank_arbiter.sv
// Shared flip-flop register bank with round-robin write arbitration
// and a sequenced one-entry-per-cycle clear sweep.
module ff_bank_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          clr_start,
  output logic                          busy,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [GW-1:0]                 last_grant
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic [GW-1:0]           ptr_q;
  logic [GW-1:0]           last_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   bank_q [DEPTH];

  logic [NUM_REQ-1:0]      gnt;
  logic                    found;
  logic [GW-1:0]           gnt_idx;
  logic [GW-1:0]           ptr_d;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    clr_last;
  int                      j;

  // Scan from the pointer upward with wrap; first valid wins.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    wr_addr = '0;
    wr_data = '0;
    j       = 0;
    if (state_q == IDLE && !clr_start) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(ptr_q) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!found && req_valid[j]) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = GW'(j);
          wr_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          wr_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    ptr_d = '0;
    if (gnt_idx != GW'(NUM_REQ-1)) ptr_d = gnt_idx + 1'b1;
  end

  assign clr_last = (cnt_q == ADDR_WIDTH'(DEPTH-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      for (int e = 0; e < DEPTH; e++) bank_q[e] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (found) begin
            ptr_q  <= ptr_d;
            last_q <= gnt_idx;
            // Out-of-range addresses match no entry and are dropped.
            for (int e = 0; e < DEPTH; e++)
              if (wr_addr == ADDR_WIDTH'(e)) bank_q[e] <= wr_data;
          end
        end
        CLEAR: begin
          for (int e = 0; e < DEPTH; e++)
            if (cnt_q == ADDR_WIDTH'(e)) bank_q[e] <= '0;
          if (clr_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int e = 0; e < DEPTH; e++)
      if (rd_addr == ADDR_WIDTH'(e)) rd_mux = bank_q[e];
  end

  assign req_ready  = gnt;
  assign busy       = busy_q;
  assign last_grant = last_q;
  assign rd_data    = rd_mux;

endmodule
